// File: rtl/read_fill_ctrl.sv
// rtl/read_fill_ctrl.sv - round-robin DRAM line-fill sequencer for instruction and data read requests
// Optional BURST stall timeout with fillErr: define READ_FILL_TIMEOUT_EN.
module read_fill_ctrl #(
   parameter int BEATS  = 8,
   parameter int ADDR_W = 27
) (
   input  logic              DRAMCLK,
   input  logic              RESET,
   input  logic              iReq,
   input  logic [ADDR_W-1:0] iAddr,
   output logic              iGrant,
   output logic              iDone,
   input  logic              dReq,
   input  logic [ADDR_W-1:0] dAddr,
   output logic              dGrant,
   output logic              dDone,
   output logic              dramCmdValid,
   output logic [ADDR_W-1:0] dramCmdAddr,
   input  logic              dramCmdReady,
   input  logic              dramDataValid,
   output logic              bufWE,
   output logic              busy,
   output logic              fillErr
);
   localparam int               CNT_W     = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, CMD, BURST, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] beat_cnt;
   logic             owner;        // 0 = I side, 1 = D side
   logic             last_served;
   logic             pick_d;
   logic             last_beat;
   logic             stall_out;

   // D wins alone, or on a tie when I was the side served last
   assign pick_d    = dReq && (!iReq || !last_served);
   assign last_beat = dramDataValid && (beat_cnt == LAST_BEAT);
   assign bufWE     = (state == BURST) && dramDataValid;

`ifdef READ_FILL_TIMEOUT_EN
   logic [7:0] stall_cnt;
   logic       err_q;

   // the 255th consecutive empty BURST cycle ends the fill
   assign stall_out = !dramDataValid && (stall_cnt == 8'd254);
   assign fillErr   = err_q;

   always_ff @(posedge DRAMCLK or negedge RESET) begin
      if (!RESET) begin
         stall_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= (state == BURST) && stall_out && !last_beat;
         if (state != BURST || dramDataValid)
            stall_cnt <= '0;
         else
            stall_cnt <= stall_cnt + 8'd1;
      end
   end
`else
   assign stall_out = 1'b0;
   assign fillErr   = 1'b0;
`endif

   always_ff @(posedge DRAMCLK or negedge RESET) begin
      if (!RESET) begin
         state        <= IDLE;
         beat_cnt     <= '0;
         owner        <= 1'b0;
         last_served  <= 1'b1;
         dramCmdAddr  <= '0;
         iGrant       <= 1'b0;
         dGrant       <= 1'b0;
         iDone        <= 1'b0;
         dDone        <= 1'b0;
         dramCmdValid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         iDone <= 1'b0;
         dDone <= 1'b0;
         case (state)
            IDLE: begin
               if (iReq || dReq) begin
                  state        <= CMD;
                  owner        <= pick_d;
                  dramCmdAddr  <= pick_d ? dAddr : iAddr;
                  iGrant       <= !pick_d;
                  dGrant       <= pick_d;
                  dramCmdValid <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            CMD: begin
               if (dramCmdReady) begin
                  state        <= BURST;
                  beat_cnt     <= '0;
                  dramCmdValid <= 1'b0;
               end
            end
            BURST: begin
               if (dramDataValid)
                  beat_cnt <= beat_cnt + 1'b1;
               if (last_beat || stall_out) begin
                  state       <= DONE;
                  last_served <= owner;
                  iDone       <= !owner;
                  dDone       <= owner;
               end
            end
            DONE: begin
               state  <= IDLE;
               iGrant <= 1'b0;
               dGrant <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end
endmodule
